// File: rtl/glitch_pkg.sv
// ---------------------------------------------------------------------------
// glitch_pkg
//   Shared definitions for the glitch lab observer blocks.
//   - state_t : two-state classifier encoding (STABLE / PULSE)
//   - WIDTH_W : width of the pulse-width counter and the reported width
// ---------------------------------------------------------------------------
package glitch_pkg;

  typedef enum logic {
    STABLE = 1'b0,
    PULSE  = 1'b1
  } state_t;

  localparam int WIDTH_W = 8;

endpackage : glitch_pkg

// File: rtl/glitch_monitor_if.sv
// ---------------------------------------------------------------------------
// glitch_monitor_if
//   Signal bundle between the monitored unit / board logic and glitch_monitor.
//   Ports carried:
//     iSig         : monitored signal, asynchronous to the system clock
//     iClear       : synchronous clear of the glitch count and last width
//     oLevel       : accepted (debounced) level of iSig
//     oGlitch      : one-cycle pulse per detected glitch
//     oLastWidth   : width in synchronized cycles of the most recent glitch
//     oGlitchCount : saturating glitch count (CNT_W bits)
//   Modports:
//     master : the side that drives iSig/iClear and consumes the results
//     slave  : the monitor itself
// ---------------------------------------------------------------------------
interface glitch_monitor_if
  import glitch_pkg::*;
#(
  parameter int CNT_W = 8
);

  logic               iSig;
  logic               iClear;
  logic               oLevel;
  logic               oGlitch;
  logic [WIDTH_W-1:0] oLastWidth;
  logic [CNT_W-1:0]   oGlitchCount;

  modport master (
    output iSig,
    output iClear,
    input  oLevel,
    input  oGlitch,
    input  oLastWidth,
    input  oGlitchCount
  );

  modport slave (
    input  iSig,
    input  iClear,
    output oLevel,
    output oGlitch,
    output oLastWidth,
    output oGlitchCount
  );

endinterface : glitch_monitor_if

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
//   Generic two-flop synchronizer for bringing asynchronous signals into the
//   iClk domain. Each bit is synchronized independently, so a multi-bit
//   instance is only suitable for unrelated single-bit signals.
//   Ports:
//     iClk   : destination clock
//     iReset : asynchronous, active-high reset (both stages cleared to 0)
//     iD     : asynchronous input
//     oQ     : synchronized output, two iClk cycles behind iD
// ---------------------------------------------------------------------------
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             iClk,
  input  logic             iReset,
  input  logic [WIDTH-1:0] iD,
  output logic [WIDTH-1:0] oQ
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // First stage may go metastable; the second stage gives it a full cycle
  // to resolve before anything downstream looks at it.
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= iD;
      r_sync <= r_meta;
    end
  end

  assign oQ = r_sync;

endmodule : sync_2ff

// File: rtl/glitch_monitor.sv
// ---------------------------------------------------------------------------
// glitch_monitor
//   Observes a combinational output and classifies every level change of the
//   synchronized signal as either a legitimate transition (held for at least
//   MIN_WIDTH cycles) or a glitch (returned to the old level sooner). Each
//   glitch raises oGlitch for one cycle, records its width and bumps a
//   saturating counter.
//   Parameters:
//     MIN_WIDTH : cycles a new level must persist to be accepted (2..255)
//     CNT_W     : width of the glitch counter; must match the interface
//   Ports:
//     iClk   : system clock
//     iReset : asynchronous, active-high reset
//     bus    : glitch_monitor_if slave (iSig, iClear in; oLevel, oGlitch,
//              oLastWidth, oGlitchCount out)
// ---------------------------------------------------------------------------
module glitch_monitor
  import glitch_pkg::*;
#(
  parameter int MIN_WIDTH = 4,
  parameter int CNT_W     = 8
) (
  input  logic            iClk,
  input  logic            iReset,
  glitch_monitor_if.slave bus
);

  // A pulse is accepted on the cycle its width would reach MIN_WIDTH, i.e.
  // when the counter still reads MIN_WIDTH-1 and the level is still new.
  localparam logic [WIDTH_W-1:0] LP_ACCEPT_AT = WIDTH_W'(MIN_WIDTH - 1);
  localparam logic [CNT_W-1:0]   LP_CNT_MAX   = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == LP_CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  logic               w_s;
  state_t             r_state;
  logic               r_lvl;
  logic [WIDTH_W-1:0] r_wcnt;
  logic               r_glitch;
  logic [WIDTH_W-1:0] r_last_width;
  logic [CNT_W-1:0]   r_count;

  sync_2ff #(
    .WIDTH (1)
  ) u_sync (
    .iClk   (iClk),
    .iReset (iReset),
    .iD     (bus.iSig),
    .oQ     (w_s)
  );

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      r_state      <= STABLE;
      r_lvl        <= 1'b0;
      r_wcnt       <= '0;
      r_glitch     <= 1'b0;
      r_last_width <= '0;
      r_count      <= '0;
    end else begin
      r_glitch <= 1'b0;

      // Clear first; a glitch detected in the same cycle overrides below so
      // that it is counted on top of the cleared value.
      if (bus.iClear) begin
        r_last_width <= '0;
        r_count      <= '0;
      end

      unique case (r_state)
        STABLE: begin
          if (w_s != r_lvl) begin
            r_state <= PULSE;
            r_wcnt  <= WIDTH_W'(1);
          end
        end

        PULSE: begin
          if (w_s == r_lvl) begin
            // Returned to the old level before being accepted: glitch.
            r_glitch     <= 1'b1;
            r_last_width <= r_wcnt;
            r_count      <= sat_inc(bus.iClear ? '0 : r_count);
            r_state      <= STABLE;
          end else if (r_wcnt == LP_ACCEPT_AT) begin
            r_lvl   <= ~r_lvl;
            r_state <= STABLE;
          end else begin
            r_wcnt <= r_wcnt + WIDTH_W'(1);
          end
        end

        default: r_state <= STABLE;
      endcase
    end
  end

  assign bus.oLevel       = r_lvl;
  assign bus.oGlitch      = r_glitch;
  assign bus.oLastWidth   = r_last_width;
  assign bus.oGlitchCount = r_count;

endmodule : glitch_monitor

// File: tb/tb_glitch_monitor.sv
module tb_glitch_monitor;
  import glitch_pkg::*;

  localparam int MINW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sig = 1'b0;
  logic clr = 1'b0;

  always #5 clk = ~clk;

  glitch_monitor_if #(.CNT_W(8)) bus8 ();
  glitch_monitor_if #(.CNT_W(2)) bus2 ();

  assign bus8.iSig   = sig;
  assign bus8.iClear = clr;
  assign bus2.iSig   = sig;
  assign bus2.iClear = clr;

  glitch_monitor #(.MIN_WIDTH(MINW), .CNT_W(8)) dut8 (
    .iClk   (clk),
    .iReset (rst),
    .bus    (bus8.slave)
  );

  glitch_monitor #(.MIN_WIDTH(MINW), .CNT_W(2)) dut2 (
    .iClk   (clk),
    .iReset (rst),
    .bus    (bus2.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int edges   = 0;
  int p8      = 0;
  int p2      = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) edges++;

  // Reference model: the signal seen by the classifier is iSig delayed by two
  // clock edges. A run of observations that differ from the accepted level is
  // either completed (MIN_WIDTH long -> level flips) or cut short (-> glitch
  // whose width is the run length).
  int m_d1, m_s, m_lvl, m_run, m_glitch, m_width, m_cnt8, m_cnt2;
  initial begin
    m_d1 = 0; m_s = 0; m_lvl = 0; m_run = 0;
    m_glitch = 0; m_width = 0; m_cnt8 = 0; m_cnt2 = 0;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_d1 = 0; m_s = 0; m_lvl = 0; m_run = 0;
      m_glitch = 0; m_width = 0; m_cnt8 = 0; m_cnt2 = 0;
    end else begin
      m_glitch = 0;
      if (clr) begin
        m_width = 0;
        m_cnt8  = 0;
        m_cnt2  = 0;
      end
      if (m_s != m_lvl) begin
        m_run = m_run + 1;
        if (m_run == MINW) begin
          m_lvl = 1 - m_lvl;
          m_run = 0;
        end
      end else if (m_run > 0) begin
        m_glitch = 1;
        m_width  = m_run;
        m_cnt8   = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
        m_cnt2   = (m_cnt2 < 3)   ? m_cnt2 + 1 : 3;
        m_run    = 0;
      end
      m_s  = m_d1;
      m_d1 = int'(sig);
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("level8", int'(bus8.oLevel),       m_lvl);
    chk("glitch8", int'(bus8.oGlitch),     m_glitch);
    chk("width8", int'(bus8.oLastWidth),   m_width);
    chk("count8", int'(bus8.oGlitchCount), m_cnt8);
    chk("level2", int'(bus2.oLevel),       m_lvl);
    chk("glitch2", int'(bus2.oGlitch),     m_glitch);
    chk("width2", int'(bus2.oLastWidth),   m_width);
    chk("count2", int'(bus2.oGlitchCount), m_cnt2);
    if (bus8.oGlitch) p8++;
    if (bus2.oGlitch) p2++;
  end

  // Inputs change 2 time units after a rising edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_glitch(input int t0, output int lat);
    lat = -1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus8.oGlitch) begin
        lat = edges - t0;
        break;
      end
    end
  endtask

  task automatic wait_level(input logic v, input int t0, output int lat);
    lat = -1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus8.oLevel == v) begin
        lat = edges - t0;
        break;
      end
    end
  endtask

  initial begin
    int t0, lat, base8, base2, run;

    // Reset state
    step(3);
    chk("rst_level", int'(bus8.oLevel), 0);
    chk("rst_glitch", int'(bus8.oGlitch), 0);
    chk("rst_width", int'(bus8.oLastWidth), 0);
    chk("rst_count", int'(bus8.oGlitchCount), 0);
    rst = 1'b0;
    step(3);

    // Single 1-cycle high pulse: glitch visible 2 + 1 + 1 edges later
    base8 = p8;
    t0 = edges; sig = 1'b1; step(1); sig = 1'b0;
    wait_glitch(t0, lat);
    chk("g1_latency", lat, 4);
    chk("g1_width", int'(bus8.oLastWidth), 1);
    chk("g1_count", int'(bus8.oGlitchCount), 1);
    chk("g1_level", int'(bus8.oLevel), 0);
    step(6);
    chk("g1_pulses", p8 - base8, 1);

    // 3-cycle high pulse
    t0 = edges; sig = 1'b1; step(3); sig = 1'b0;
    wait_glitch(t0, lat);
    chk("g3_latency", lat, 6);
    chk("g3_width", int'(bus8.oLastWidth), 3);
    chk("g3_count", int'(bus8.oGlitchCount), 2);
    step(4);

    // 4-cycle (held) high: legitimate, level rises 2 + 4 edges after drive
    base8 = p8;
    t0 = edges; sig = 1'b1;
    wait_level(1'b1, t0, lat);
    chk("rise_latency", lat, 6);
    step(3);
    chk("rise_no_glitch", p8 - base8, 0);
    chk("rise_count", int'(bus8.oGlitchCount), 2);

    // 2-cycle low pulse while level is 1
    t0 = edges; sig = 1'b0; step(2); sig = 1'b1;
    wait_glitch(t0, lat);
    chk("low2_latency", lat, 5);
    chk("low2_width", int'(bus8.oLastWidth), 2);
    chk("low2_count", int'(bus8.oGlitchCount), 3);
    chk("low2_level", int'(bus8.oLevel), 1);
    step(4);
    t0 = edges; sig = 1'b0;
    wait_level(1'b0, t0, lat);
    chk("fall_latency", lat, 6);
    step(3);

    // Saturation of the 2-bit counter: five glitches, count holds at 3
    rst = 1'b1; step(1); rst = 1'b0; step(2);
    base8 = p8; base2 = p2;
    for (int i = 0; i < 5; i++) begin
      sig = 1'b1; step(1); sig = 1'b0; step(5);
    end
    chk("sat_pulses2", p2 - base2, 5);
    chk("sat_count2", int'(bus2.oGlitchCount), 3);
    chk("sat_count8", int'(bus8.oGlitchCount), 5);

    // Bring count to 7, then clear in the same cycle as a width-2 glitch
    for (int i = 0; i < 2; i++) begin
      sig = 1'b1; step(1); sig = 1'b0; step(5);
    end
    chk("pre_clear_count", int'(bus8.oGlitchCount), 7);
    sig = 1'b1; step(2); sig = 1'b0; step(2);
    clr = 1'b1; step(1); clr = 1'b0;
    chk("clrg_glitch", int'(bus8.oGlitch), 1);
    chk("clrg_count", int'(bus8.oGlitchCount), 1);
    chk("clrg_width", int'(bus8.oLastWidth), 2);
    step(3);
    clr = 1'b1; step(1); clr = 1'b0;
    chk("clr_idle_count", int'(bus8.oGlitchCount), 0);
    chk("clr_idle_width", int'(bus8.oLastWidth), 0);
    chk("clr_idle_count2", int'(bus2.oGlitchCount), 0);

    // Reset mid-stream and mid-pulse
    sig = 1'b1; step(1); sig = 1'b0; step(6);
    chk("pre_rst_count", int'(bus8.oGlitchCount), 1);
    sig = 1'b1; step(2);
    rst = 1'b1; #1;
    chk("async_rst_count", int'(bus8.oGlitchCount), 0);
    chk("async_rst_width", int'(bus8.oLastWidth), 0);
    chk("async_rst_level", int'(bus8.oLevel), 0);
    chk("async_rst_glitch", int'(bus8.oGlitch), 0);
    step(1);
    rst = 1'b0;
    base8 = p8;
    t0 = edges;
    wait_level(1'b1, t0, lat);
    chk("post_rst_rise", lat, 6);
    step(4);
    chk("post_rst_no_glitch", p8 - base8, 0);

    // Randomized stretch: random run lengths, occasional clear and reset
    run = 0;
    for (int c = 0; c < 3000; c++) begin
      if (run == 0) begin
        sig = ~sig;
        run = int'($urandom_range(1, 7));
      end
      run--;
      clr = ($urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 499) == 0);
      step(1);
    end
    clr = 1'b0;
    rst = 1'b0;
    step(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_glitch_monitor
